// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor drive output stage.
// Defines speed and steering codes, the FSM state encoding and the speed-to-duty map.
package motor_pkg;

    typedef enum logic [1:0] {
        StOff   = 2'd0,
        StRun   = 2'd1,
        StBrake = 2'd2
    } state_e;

    localparam logic [2:0] SPEED_STOP = 3'd0;
    localparam logic [2:0] SPEED_SLOW = 3'd1;
    localparam logic [2:0] SPEED_MED  = 3'd2;
    localparam logic [2:0] SPEED_HIGH = 3'd3;

    localparam logic [1:0] STEER_STRAIGHT = 2'd0;
    localparam logic [1:0] STEER_RIGHT    = 2'd1;
    localparam logic [1:0] STEER_LEFT     = 2'd2;

    // Codes 4..7 are unused by the upstream controller and map to a stop.
    function automatic int unsigned speed_to_duty(input logic [2:0] code,
                                                  input int unsigned slow,
                                                  input int unsigned med,
                                                  input int unsigned high);
        case (code)
            SPEED_STOP: return 0;
            SPEED_SLOW: return slow;
            SPEED_MED:  return med;
            SPEED_HIGH: return high;
            default:    return 0;
        endcase
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Single-wheel PWM generator: free-running counter, duty latched at the period
// boundary so a new duty never takes effect mid-period, registered compare.
module pwm_gen #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                run,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm
);

    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] latch_q;
    logic                pwm_q;

    // Counter, period-boundary duty latch and compare; all held clear while stopped.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q   <= '0;
            latch_q <= '0;
            pwm_q   <= 1'b0;
        end else if (!run) begin
            cnt_q   <= '0;
            latch_q <= '0;
            pwm_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (&cnt_q) begin
                latch_q <= duty;
            end
            pwm_q <= (cnt_q < latch_q);
        end
    end

    // Gate with run so the output drops the same cycle the drive turns off.
    assign pwm = pwm_q & run;

endmodule

// File: rtl/motor_drive.sv
// Motor H-bridge and lamp driver fed by the car control FSM.
// Ramped wheel duty, differential steering, brake lamp and blinking indicators.
// Build option: define MOTOR_SOFT_RAMP_EN for prescaled ramp/brake stepping;
// without it the duty jumps straight to target (RUN) or to zero (BRAKE).
module motor_drive
    import motor_pkg::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned RAMP_DIV   = 1024,
    parameter int unsigned RAMP_STEP  = 4,
    parameter int unsigned BRAKE_STEP = 16,
    parameter int unsigned DUTY_SLOW  = 64,
    parameter int unsigned DUTY_MED   = 128,
    parameter int unsigned DUTY_HIGH  = 224,
    parameter int unsigned BLINK_HALF = 12500000
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                en,
    input  logic [2:0]          speed,
    input  logic [1:0]          steer,
    input  logic                tl,
    input  logic                rh,
    input  logic                lh,
    output logic                pwm_l,
    output logic                pwm_r,
    output logic                brake_lamp,
    output logic                ind_l,
    output logic                ind_r,
    output logic [PWM_BITS-1:0] duty_cur,
    output logic                at_target
);

    localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);

    state_e              state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] duty_l, duty_r;
    logic                at_target_q, at_target_d;
    logic                run;

    assign target = PWM_BITS'(speed_to_duty(speed, DUTY_SLOW, DUTY_MED, DUTY_HIGH));
    assign run    = (state_q != StOff);

    // Next-state logic; dropping en wins over everything, including tl.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = StOff;
        end else begin
            unique case (state_q)
                StOff:   state_d = StRun;
                StRun:   if (tl)  state_d = StBrake;
                StBrake: if (!tl) state_d = StRun;
                default: state_d = StOff;
            endcase
        end
    end

`ifdef MOTOR_SOFT_RAMP_EN
    localparam int unsigned PRE_W = $clog2(RAMP_DIV + 1);
    localparam logic [PWM_BITS-1:0] RSTEP = PWM_BITS'(RAMP_STEP);
    localparam logic [PWM_BITS-1:0] BSTEP = PWM_BITS'(BRAKE_STEP);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic             tick;

    assign tick = run && (presc_q == PRE_W'(RAMP_DIV - 1));

    // Prescaler restarts on every entry to RUN so the first step lands a full tick later.
    always_comb begin
        presc_d = presc_q + 1'b1;
        if (state_d == StOff || (state_d == StRun && state_q != StRun) || tick) begin
            presc_d = '0;
        end
    end

    // Ramp prescaler register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) presc_q <= '0;
        else        presc_q <= presc_d;
    end

    // Duty stepping: approach target without overshoot in RUN, saturating decay in BRAKE.
    always_comb begin
        duty_d = duty_q;
        if (!en) begin
            duty_d = '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (tick) begin
                        if (duty_q < target) begin
                            duty_d = (target - duty_q > RSTEP) ? duty_q + RSTEP : target;
                        end else if (duty_q > target) begin
                            duty_d = (duty_q - target > RSTEP) ? duty_q - RSTEP : target;
                        end
                    end
                end
                StBrake: begin
                    if (tick) begin
                        duty_d = (duty_q > BSTEP) ? duty_q - BSTEP : '0;
                    end
                end
                default: duty_d = '0;
            endcase
        end
    end
`else
    // Duty follows target directly in RUN and collapses to zero in BRAKE.
    always_comb begin
        duty_d = '0;
        if (en && state_q == StRun) begin
            duty_d = target;
        end
    end
`endif

    // Only report on-target while staying in RUN, so leaving RUN clears it at once.
    always_comb begin
        at_target_d = (state_q == StRun) && (state_d == StRun) && (duty_q == target);
    end

    // State, duty and at-target registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= StOff;
            duty_q      <= '0;
            at_target_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            at_target_q <= at_target_d;
        end
    end

    // Differential steering: the inside wheel runs at half duty.
    always_comb begin
        duty_l = duty_q;
        duty_r = duty_q;
        case (steer)
            STEER_STRAIGHT: ;
            STEER_RIGHT:    duty_r = duty_q >> 1;
            STEER_LEFT:     duty_l = duty_q >> 1;
            default:        ;
        endcase
    end

    pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm_l (
        .clk   (clk),
        .clr_n (clr_n),
        .run   (run),
        .duty  (duty_l),
        .pwm   (pwm_l)
    );

    pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm_r (
        .clk   (clk),
        .clr_n (clr_n),
        .run   (run),
        .duty  (duty_r),
        .pwm   (pwm_r)
    );

    logic               lh_q, rh_q;
    logic [BLINK_W-1:0] blink_q;
    logic               phase_q;
    logic               ind_rise;

    assign ind_rise = (lh & ~lh_q) | (rh & ~rh_q);

    // Blink timer; a fresh indicator request restarts it in the lit phase.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            lh_q    <= 1'b0;
            rh_q    <= 1'b0;
            blink_q <= '0;
            phase_q <= 1'b0;
        end else begin
            lh_q <= lh;
            rh_q <= rh;
            if (ind_rise) begin
                blink_q <= '0;
                phase_q <= 1'b1;
            end else if (blink_q == BLINK_W'(BLINK_HALF - 1)) begin
                blink_q <= '0;
                phase_q <= ~phase_q;
            end else begin
                blink_q <= blink_q + 1'b1;
            end
        end
    end

    assign ind_l      = en & lh & phase_q;
    assign ind_r      = en & rh & phase_q;
    assign brake_lamp = (state_q == StBrake);
    assign duty_cur   = duty_q;
    assign at_target  = at_target_q;

endmodule

// File: tb/tb_motor_drive.sv
// Directed self-checking bench for motor_drive (RAMP_DIV=4, BLINK_HALF=8).
// Covers both builds of MOTOR_SOFT_RAMP_EN.
module tb_motor_drive;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       en = 1'b0;
    logic [2:0] speed = 3'd0;
    logic [1:0] steer = 2'd0;
    logic       tl = 1'b0;
    logic       rh = 1'b0;
    logic       lh = 1'b0;
    logic       pwm_l, pwm_r, brake_lamp, ind_l, ind_r, at_target;
    logic [7:0] duty_cur;

    int checks = 0;
    int errors = 0;
    int hl, hr;

    always #5 clk = ~clk;

    motor_drive #(
        .PWM_BITS   (8),
        .RAMP_DIV   (4),
        .RAMP_STEP  (4),
        .BRAKE_STEP (16),
        .DUTY_SLOW  (64),
        .DUTY_MED   (128),
        .DUTY_HIGH  (224),
        .BLINK_HALF (8)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .en         (en),
        .speed      (speed),
        .steer      (steer),
        .tl         (tl),
        .rh         (rh),
        .lh         (lh),
        .pwm_l      (pwm_l),
        .pwm_r      (pwm_r),
        .brake_lamp (brake_lamp),
        .ind_l      (ind_l),
        .ind_r      (ind_r),
        .duty_cur   (duty_cur),
        .at_target  (at_target)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count high cycles of each wheel over one full PWM period.
    task automatic measure();
        hl = 0;
        hr = 0;
        repeat (256) begin
            @(posedge clk);
            #1;
            hl += int'(pwm_l);
            hr += int'(pwm_r);
        end
    endtask

    initial begin
        // Reset state
        step(2);
        check("rst_duty", duty_cur, 0);
        check("rst_pwm_l", pwm_l, 0);
        check("rst_brake", brake_lamp, 0);
        check("rst_at_target", at_target, 0);
        check("rst_ind", {ind_l, ind_r}, 0);
        clr_n = 1'b1;

        // Ramp up to medium speed
        en = 1'b1;
        speed = 3'd2;
`ifdef MOTOR_SOFT_RAMP_EN
        step(1);
        check("ramp_start", duty_cur, 0);
        step(4);
        check("ramp_tick1", duty_cur, 4);
        step(4);
        check("ramp_tick2", duty_cur, 8);
        step(119);
        check("ramp_tick31", duty_cur, 124);
        step(1);
        check("ramp_tick32", duty_cur, 128);
        check("ramp_at_target_lag", at_target, 0);
        step(1);
        check("ramp_at_target", at_target, 1);
`else
        step(1);
        check("load_start", duty_cur, 0);
        step(1);
        check("load_target", duty_cur, 128);
        check("load_at_target_lag", at_target, 0);
        step(1);
        check("load_at_target", at_target, 1);
`endif

        // PWM duty at 128/256
        step(600);
        measure();
        check("pwm_l_128", hl, 128);
        check("pwm_r_128", hr, 128);

        // Brake and recovery; speed change during brake is ignored
        tl = 1'b1;
        step(1);
        check("brake_lamp_on", brake_lamp, 1);
        check("brake_at_target", at_target, 0);
`ifdef MOTOR_SOFT_RAMP_EN
        step(40);
        check("brake_floor", duty_cur, 0);
        speed = 3'd3;
        step(8);
        check("brake_no_underflow", duty_cur, 0);
        speed = 3'd2;
        tl = 1'b0;
        step(200);
        check("brake_recover", duty_cur, 128);
        check("brake_recover_at", at_target, 1);
`else
        check("brake_first_cycle", duty_cur, 128);
        step(1);
        check("brake_drop", duty_cur, 0);
        speed = 3'd3;
        step(2);
        check("brake_ignore_speed", duty_cur, 0);
        speed = 3'd2;
        tl = 1'b0;
        step(1);
        check("brake_lamp_off", brake_lamp, 0);
        step(1);
        check("brake_recover", duty_cur, 128);
        step(1);
        check("brake_recover_at", at_target, 1);
`endif
        check("brake_lamp_run", brake_lamp, 0);

        // Differential steering at slow speed
        speed = 3'd1;
        steer = 2'd1;
        step(600);
        measure();
        check("right_pwm_l", hl, 64);
        check("right_pwm_r", hr, 32);
        steer = 2'd3;
        step(600);
        measure();
        check("steer3_pwm_l", hl, 64);
        check("steer3_pwm_r", hr, 64);
        steer = 2'd2;
        step(600);
        measure();
        check("left_pwm_l", hl, 32);
        check("left_pwm_r", hr, 64);
        steer = 2'd0;

        // Indicators
        lh = 1'b1;
        step(1);
        check("ind_l_first", ind_l, 1);
        check("ind_r_idle", ind_r, 0);
        step(7);
        check("ind_l_hold", ind_l, 1);
        step(1);
        check("ind_l_toggle", ind_l, 0);
        rh = 1'b1;
        step(1);
        check("hazard_on", {ind_l, ind_r}, 3);
        step(7);
        check("hazard_hold", {ind_l, ind_r}, 3);
        step(1);
        check("hazard_off", {ind_l, ind_r}, 0);
        step(8);
        check("hazard_on2", {ind_l, ind_r}, 3);
        en = 1'b0;
        #1;
        check("ind_en_low", {ind_l, ind_r}, 0);
        lh = 1'b0;
        rh = 1'b0;
        step(2);

        // en drop while braking
        en = 1'b1;
        tl = 1'b1;
        speed = 3'd3;
        step(2);
        check("endrop_brake_on", brake_lamp, 1);
`ifndef MOTOR_SOFT_RAMP_EN
        check("endrop_duty_before", duty_cur, 224);
`endif
        en = 1'b0;
        step(1);
        check("endrop_brake_off", brake_lamp, 0);
        check("endrop_duty", duty_cur, 0);
        check("endrop_pwm", {pwm_l, pwm_r}, 0);
`ifndef MOTOR_SOFT_RAMP_EN
        en = 1'b1;
        tl = 1'b0;
        step(2);
        check("high_load", duty_cur, 224);
`endif

        // Asynchronous reset mid-ramp
        en = 1'b0;
        tl = 1'b0;
        step(1);
        en = 1'b1;
        speed = 3'd2;
`ifdef MOTOR_SOFT_RAMP_EN
        step(41);
        check("midramp_duty", duty_cur, 40);
`else
        step(2);
        check("midramp_duty", duty_cur, 128);
`endif
        #3;
        clr_n = 1'b0;
        #1;
        check("async_rst_duty", duty_cur, 0);
        check("async_rst_pwm", {pwm_l, pwm_r}, 0);
        check("async_rst_lamps", {brake_lamp, ind_l, ind_r, at_target}, 0);
        en = 1'b0;
        #2;
        clr_n = 1'b1;
        step(1);
        check("post_rst_duty", duty_cur, 0);
        check("post_rst_brake", brake_lamp, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
